// File: rtl/seq_go_done_ctrl.sv
// seq_go_done_ctrl: go/done initiator that runs NUM_STEPS children in order, repeated a latched number of times.
// Optional per-step watchdog with ERR state when SEQ_GO_DONE_TIMEOUT_EN is defined.
module seq_go_done_ctrl #(
    parameter int NUM_STEPS = 4,
    parameter int ITER_W    = 8,
    parameter int TIMEOUT_W = 8,
    localparam int IDX_W    = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 go,
    input  logic [ITER_W-1:0]    iters,
    output logic                 done,
    output logic                 busy,
    output logic [NUM_STEPS-1:0] child_go,
    input  logic [NUM_STEPS-1:0] child_done,
    output logic [IDX_W-1:0]     step_idx,
    output logic [ITER_W-1:0]    iter_cnt,
    output logic                 error
);
    typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

    state_t            state, state_n;
    logic [ITER_W-1:0] iters_q;
    logic [ITER_W-1:0] iter_inc;
    logic              step_done;
    logic              last_step;
    logic              more;
    logic              start;
    logic              timeout;

    // Only the active child's done matters; strays on other bits are ignored.
    assign step_done = child_done[step_idx];
    assign last_step = step_idx == IDX_W'(NUM_STEPS - 1);
    assign iter_inc  = iter_cnt + ITER_W'(1);
    assign more      = iter_inc < iters_q;
    assign start     = state == IDLE && go;

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = !go ? IDLE : (iters != '0 ? RUN : DONE);
            RUN:     state_n = !go ? IDLE : timeout ? ERR :
                               (step_done && last_step && !more) ? DONE : RUN;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy     = state == RUN;
        done     = state == DONE || state == ERR;
        child_go = busy ? NUM_STEPS'(1) << step_idx : '0;
    end

    // An abort leaves step_idx/iter_cnt untouched so the parent can see where it stopped.
    always_ff @(posedge clk) begin
        if (reset) begin
            iters_q  <= '0;
            step_idx <= '0;
            iter_cnt <= '0;
        end else if (start) begin
            iters_q  <= iters;
            step_idx <= '0;
            iter_cnt <= '0;
        end else if (state == RUN && go && step_done) begin
            step_idx <= !last_step ? step_idx + IDX_W'(1) : more ? '0 : step_idx;
            iter_cnt <= last_step ? iter_inc : iter_cnt;
        end
    end

`ifdef SEQ_GO_DONE_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] timer;

    // Trip on the edge where the idle count would reach all-ones.
    assign timeout = state == RUN && !step_done && (timer + TIMEOUT_W'(1)) == '1;

    always_ff @(posedge clk) begin
        if (reset) begin
            timer <= '0;
            error <= 1'b0;
        end else begin
            timer <= (start || state != RUN || step_done) ? '0 : timer + TIMEOUT_W'(1);
            error <= state_n == ERR ? 1'b1 : start ? 1'b0 : error;
        end
    end
`else
    assign timeout = 1'b0;
    assign error   = 1'b0;
`endif

endmodule

// File: tb/tb_seq_go_done_ctrl.sv
// tb_seq_go_done_ctrl: scoreboard bench; expected per-cycle outputs are queued at start and popped each cycle.
module tb_seq_go_done_ctrl;
    localparam int N  = 4;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          go = 1'b0;
    logic [IW-1:0] iters = '0;
    logic          done, busy, error;
    logic [N-1:0]  child_go, child_done;
    logic [1:0]    step_idx;
    logic [IW-1:0] iter_cnt;

    logic          comb_mode = 1'b0;
    logic [N-1:0]  mute = '0;
    logic [N-1:0]  stray = '0;
    logic [N-1:0]  done_q;

    typedef struct packed {
        logic [3:0] cg;
        logic       d;
        logic       b;
        logic       e;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    seq_go_done_ctrl #(.NUM_STEPS(N), .ITER_W(IW), .TIMEOUT_W(4)) dut (
        .clk(clk), .reset(reset), .go(go), .iters(iters), .done(done), .busy(busy),
        .child_go(child_go), .child_done(child_done), .step_idx(step_idx),
        .iter_cnt(iter_cnt), .error(error)
    );

    always #5 clk = ~clk;

    // Children: registered (done one cycle after go) or combinational, with mute and stray injection.
    always_ff @(posedge clk) done_q <= reset ? '0 : child_go & ~done_q & ~mute;
    assign child_done = (comb_mode ? child_go & ~mute : done_q) | stray;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("child_go", 32'(child_go), 32'(e.cg));
            check("done", 32'(done), 32'(e.d));
            check("busy", 32'(busy), 32'(e.b));
            check("error", 32'(error), 32'(e.e));
        end
    end

    function automatic void push(input logic [3:0] cg, input logic d, input logic b, input logic e);
        q.push_back({cg, d, b, e});
    endfunction

    function automatic void push_step(input int s, input int n);
        for (int i = 0; i < n; i++) push(4'(1) << s, 1'b0, 1'b1, 1'b0);
    endfunction

    task automatic start(input logic [IW-1:0] n, input logic comb);
        @(negedge clk);
        #1;
        iters     = n;
        comb_mode = comb;
        go        = 1'b1;
    endtask

    // Drains the expected trace, playing the parent role and timed events by cycle number.
    task automatic wait_run(input int abort_at, input int unmute_at, input int stray_to, input int reset_at);
        int c = 0;
        while (q.size() > 0 && c < 200) begin
            @(negedge clk);
            #1;
            c++;
            if (done) go = 1'b0;
            if (c == 1) iters = 1;
            if (c == abort_at) go = 1'b0;
            if (c == unmute_at) mute = '0;
            if (c == stray_to) stray = '0;
            if (c == reset_at) begin
                reset = 1'b1;
                go    = 1'b0;
            end
            if (c == reset_at + 1) reset = 1'b0;
        end
        if (q.size() > 0) begin
            check("trace_drain", 32'(q.size()), 32'd0);
            q.delete();
        end
        go    = 1'b0;
        mute  = '0;
        stray = '0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_child_go", 32'(child_go), 32'd0);
        check("rst_step_idx", 32'(step_idx), 32'd0);
        check("rst_iter_cnt", 32'(iter_cnt), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        #1 reset = 1'b0;

        start(1, 1'b0);
        for (int s = 0; s < 4; s++) push_step(s, 2);
        push(4'b0, 1'b1, 1'b0, 1'b0);
        push(4'b0, 1'b0, 1'b0, 1'b0);
        wait_run(0, 0, 0, 0);
        check("basic_iter_cnt", 32'(iter_cnt), 32'd1);

        start(3, 1'b1);
        for (int r = 0; r < 3; r++)
            for (int s = 0; s < 4; s++) push_step(s, 1);
        push(4'b0, 1'b1, 1'b0, 1'b0);
        push(4'b0, 1'b0, 1'b0, 1'b0);
        wait_run(0, 0, 0, 0);
        check("repeat_iter_cnt", 32'(iter_cnt), 32'd3);

        start(0, 1'b0);
        push(4'b0, 1'b1, 1'b0, 1'b0);
        push(4'b0, 1'b0, 1'b0, 1'b0);
        push(4'b0, 1'b0, 1'b0, 1'b0);
        wait_run(0, 0, 0, 0);

        start(1, 1'b0);
        push_step(0, 2);
        push_step(1, 2);
        push_step(2, 1);
        push(4'b0, 1'b0, 1'b0, 1'b0);
        push(4'b0, 1'b0, 1'b0, 1'b0);
        wait_run(5, 0, 0, 0);
        check("abort_step_idx", 32'(step_idx), 32'd2);
        check("abort_iter_cnt", 32'(iter_cnt), 32'd0);

        start(1, 1'b0);
        push_step(0, 2);
        push_step(1, 1);
        push(4'b0, 1'b0, 1'b0, 1'b0);
        push(4'b0, 1'b0, 1'b0, 1'b0);
        wait_run(0, 0, 0, 3);
        check("reset_step_idx", 32'(step_idx), 32'd0);
        check("reset_iter_cnt", 32'(iter_cnt), 32'd0);

        mute  = 4'b0001;
        stray = 4'b1000;
        start(1, 1'b0);
        push_step(0, 4);
        for (int s = 1; s < 4; s++) push_step(s, 2);
        push(4'b0, 1'b1, 1'b0, 1'b0);
        push(4'b0, 1'b0, 1'b0, 1'b0);
        wait_run(0, 3, 3, 0);
        check("stray_iter_cnt", 32'(iter_cnt), 32'd1);

`ifdef SEQ_GO_DONE_TIMEOUT_EN
        mute = 4'b0010;
        start(1, 1'b0);
        push_step(0, 2);
        push_step(1, 15);
        push(4'b0, 1'b1, 1'b0, 1'b1);
        push(4'b0, 1'b0, 1'b0, 1'b1);
        wait_run(0, 0, 0, 0);

        start(0, 1'b0);
        push(4'b0, 1'b1, 1'b0, 1'b0);
        push(4'b0, 1'b0, 1'b0, 1'b0);
        wait_run(0, 0, 0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end
endmodule
